bits_decoder: RTL and testbench
===============================

# bits_decoder

Reassembles words from the alternating bit-position / bit-value stream produced by the team's bit-serializing QA wrapper. Consumes pairs (position, value) from bit WIDTH-1 down to bit 0 and emits the rebuilt word. Checks the stream strictly, and latches a sticky error on any protocol violation or upstream error code. Sits on the host/QA side of the UHD test path, so captured serial dumps can be checked word-for-word.

## Interface
- WIDTH, 32: word width, and width of every stream word.
- LOG_WIDTH, 5: width of the internal bit-position counter; must equal clog2(WIDTH).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  WIDTH  stream word, either a position or a value.
- in_nd  in  1  in_data valid this cycle.
- out_data  out  WIDTH  reassembled word.
- out_nd  out  1  one-cycle strobe: out_data is a new complete word.
- busy  out  1  a word is partially received.
- error  out  1  sticky protocol error.
- err_cause  out  2  cause of the error:
  - 0: none
  - 1: bad position
  - 2: bad value
  - 3: ERRORCODE received

## Operation
- States:
  - IDLE: expect position WIDTH-1.
  - EXP_VAL: expect a value.
  - EXP_POS: expect the next position.
  - ERR: error latched.
- Cycles with in_nd=0 never change state, whatever the state. Gaps of any length are allowed between stream words.
- In IDLE or EXP_POS, a word with in_nd=1 is a position:
  - The full WIDTH-bit word must equal the expected position: WIDTH-1 in IDLE, otherwise bit_pos-1.
  - On a match, load bit_pos and go to EXP_VAL.
- In EXP_VAL, a word with in_nd=1 is a value:
  - The full word must be 0 or 1.
  - Write in_data[0] into shift[bit_pos].
  - If bit_pos==0: copy shift into out_data, pulse out_nd, go to IDLE.
  - Otherwise go to EXP_POS.
- ERRORCODE check:
  - Applies to any word with in_nd=1, in any non-ERR state.
  - It takes priority over the position and value checks.
  - Result: err_cause=3, go to ERR.
- Mismatches:
  - A position mismatch gives err_cause=1.
  - A value outside {0,1} gives err_cause=2.
  - Either one goes to ERR.
- ERR:
  - error=1 and err_cause are held.
  - out_nd is held at 0 and in_nd is ignored.
  - The only exit is reset.
  - The partial word is discarded; out_data keeps its last good word.
- busy = 1 in EXP_VAL and EXP_POS, else 0.
- bit_pos is LOG_WIDTH bits wide and never wraps: position 0 always ends the word.

## Timing
- Reset values: out_data=0, out_nd=0, busy=0, error=0, err_cause=0, state=IDLE, shift=0.
- Reset is asynchronous on assertion; release is synchronous to clk.
- All outputs are registered.
- out_nd rises the cycle after the clock edge that samples the value word for bit 0. Latency is 1 cycle.
- A full word takes 2*WIDTH accepted stream words; the minimum is 2*WIDTH cycles at one word per cycle.
- Back-to-back words: position WIDTH-1 may arrive on the cycle immediately after the last value. It is accepted with no bubble, and out_nd for the previous word is still asserted that cycle.
- error and err_cause assert the cycle after the offending word is sampled. The state is already ERR from that cycle on.
- Reset mid-word drops the partial word; out_nd does not fire for it.

## Structure
- A shared package (or the team's shared defines header) holds:
  - ERRORCODE, the same constant the serializer emits (all-ones for WIDTH=32);
  - the err_cause encodings 0–3;
  - the state encodings.
- One sub-module is natural: bits_decoder_check.
  - It is purely combinational.
  - It classifies a stream word against the expected position or value.
  - Outputs: ok / bad_pos / bad_val / is_errcode.
- The FSM, shift register and output registers stay in the top module.

## Test plan
- **Single word:** send pairs (31,1),(30,0),…,(0,1) for 0xA5A5A5A5 at one word per cycle → exactly one out_nd, out_data=0xA5A5A5A5, error=0.
- **Back-to-back words:** 0x00000001 then 0x80000000 with no gap, then random in_nd gaps → two out_nd strobes carrying those values, busy low only between words.
- **Skipped position:** positions 31, 30, then 28 → error=1 and err_cause=1 one cycle after the 28 is sampled. No out_nd follows, and further traffic is ignored.
- **Bad value:** value word 2 at bit 31 → err_cause=2 and error sticks. After reset, a clean 0xFFFF0000 decodes correctly.
- **Upstream error:** ERRORCODE arrives while in EXP_VAL → err_cause=3, even though 0xFFFFFFFF would otherwise be a bad value.
- **Reset mid-word:** assert reset after 20 pairs → all outputs return to their reset values immediately. A fresh word 0x12345678 then decodes with exactly one out_nd.

Source files
------------

// File: rtl/bits_decoder_pkg.sv
// Shared constants for the bit-serial stream decoder: stream error code,
// error-cause encodings and FSM state encodings.
package bits_decoder_pkg;

  // The serializer signals an upstream fault with an all-ones word. Callers
  // truncate this to their own WIDTH.
  localparam logic [63:0] ERRORCODE = '1;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_BAD_POS = 2'd1;
  localparam logic [1:0] CAUSE_BAD_VAL = 2'd2;
  localparam logic [1:0] CAUSE_ERRCODE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXP_VAL = 2'd1,
    ST_EXP_POS = 2'd2,
    ST_ERR     = 2'd3
  } state_t;

endpackage

// File: rtl/bits_decoder_check.sv
// Combinational classifier: judges one stream word against the expected
// position, or as a value, and flags the upstream error code.
module bits_decoder_check
  import bits_decoder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 is_val,
  input  logic [LOG_WIDTH-1:0] exp_pos,
  output logic                 ok,
  output logic                 bad_pos,
  output logic                 bad_val,
  output logic                 is_errcode
);

  logic pos_match;
  logic val_ok;

  // Whole-word compares: stray upper bits are a protocol error.
  assign pos_match  = (in_data == WIDTH'(exp_pos));
  assign val_ok     = (in_data[WIDTH-1:1] == '0);
  assign is_errcode = (in_data == WIDTH'(ERRORCODE));

  assign bad_pos = !is_errcode && !is_val && !pos_match;
  assign bad_val = !is_errcode &&  is_val && !val_ok;
  assign ok      = !is_errcode && (is_val ? val_ok : pos_match);

endmodule

// File: rtl/bits_decoder.sv
// Rebuilds WIDTH-bit words from a (position, value) pair stream, MSB first,
// with a sticky error on any protocol violation.
module bits_decoder
  import bits_decoder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             busy,
  output logic             error,
  output logic [1:0]       err_cause
);

  state_t               state;
  logic [LOG_WIDTH-1:0] bit_pos;
  logic [WIDTH-1:0]     shift;
  logic [LOG_WIDTH-1:0] exp_pos;
  logic                 ok;
  logic                 bad_pos;
  logic                 bad_val;
  logic                 is_errcode;

  // bit_pos is never 0 in EXP_POS, so the decrement cannot wrap.
  assign exp_pos = (state == ST_IDLE) ? LOG_WIDTH'(WIDTH-1) : bit_pos - 1'b1;

  bits_decoder_check #(
    .WIDTH     (WIDTH),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_check (
    .in_data    (in_data),
    .is_val     (state == ST_EXP_VAL),
    .exp_pos    (exp_pos),
    .ok         (ok),
    .bad_pos    (bad_pos),
    .bad_val    (bad_val),
    .is_errcode (is_errcode)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_pos   <= '0;
      shift     <= '0;
      out_data  <= '0;
      out_nd    <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      err_cause <= CAUSE_NONE;
    end else begin
      out_nd <= 1'b0;
      if (state != ST_ERR && in_nd) begin
        if (!ok) begin
          state     <= ST_ERR;
          busy      <= 1'b0;
          error     <= 1'b1;
          err_cause <= is_errcode ? CAUSE_ERRCODE :
                       bad_pos    ? CAUSE_BAD_POS :
                       bad_val    ? CAUSE_BAD_VAL : CAUSE_NONE;
        end else if (state == ST_EXP_VAL) begin
          shift[bit_pos] <= in_data[0];
          if (bit_pos == '0) begin
            // Bit 0 lands in shift this same edge, so splice it in directly.
            out_data <= {shift[WIDTH-1:1], in_data[0]};
            out_nd   <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            state <= ST_EXP_POS;
          end
        end else begin
          bit_pos <= in_data[LOG_WIDTH-1:0];
          busy    <= 1'b1;
          state   <= ST_EXP_VAL;
        end
      end
    end
  end

endmodule

// File: tb/tb_bits_decoder.sv
// Scoreboard bench for bits_decoder: expected words are queued as stimulus
// is driven and popped on every out_nd strobe.
module tb_bits_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_nd = 1'b0;
  logic [31:0] out_data;
  logic        out_nd;
  logic        busy;
  logic        error;
  logic [1:0]  err_cause;

  int          checks = 0;
  int          errors = 0;
  int          nd_cnt = 0;
  logic [31:0] sb_q[$];

  bits_decoder #(.WIDTH(32), .LOG_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_nd     (in_nd),
    .out_data  (out_data),
    .out_nd    (out_nd),
    .busy      (busy),
    .error     (error),
    .err_cause (err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && out_nd) begin
      nd_cnt++;
      if (sb_q.size() == 0) chk("spurious_nd", 32'd1, 32'd0);
      else chk("out_data", out_data, sb_q.pop_front());
    end
  end

  task automatic idle(input int n);
    in_nd = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [31:0] d);
    in_data = d;
    in_nd   = 1'b1;
    @(posedge clk);
    #1;
    in_nd   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    sb_q.push_back(w);
    for (int i = 31; i >= 0; i--) begin
      put(32'(i));
      if (i == 31) chk("busy_mid", {31'd0, busy}, 32'd1);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      put({31'd0, w[i]});
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_nd"},    {31'd0, out_nd}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_err"},   {31'd0, error}, 32'd0);
    chk({tag, "_cause"}, {30'd0, err_cause}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk_reset_vals("rst");
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  initial begin
    int n0;
    idle(3);
    chk_reset_vals("por");
    reset = 1'b1;
    idle(1);

    // single word
    n0 = nd_cnt;
    send_word(32'hA5A5A5A5, 0);
    idle(3);
    chk("single_cnt", 32'(nd_cnt - n0), 32'd1);
    chk("single_err", {31'd0, error}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd0);

    // back-to-back, then gapped traffic
    n0 = nd_cnt;
    send_word(32'h00000001, 0);
    send_word(32'h80000000, 0);
    idle(2);
    chk("b2b_cnt", 32'(nd_cnt - n0), 32'd2);
    send_word(32'h3C5A_0F96, 3);
    send_word(32'hDEADBEEF, 2);
    idle(3);
    chk("gap_cnt", 32'(nd_cnt - n0), 32'd4);
    chk("gap_pending", 32'(sb_q.size()), 32'd0);

    // skipped position
    n0 = nd_cnt;
    put(32'd31); put(32'd1); put(32'd30); put(32'd0);
    chk("skip_pre_err", {31'd0, error}, 32'd0);
    put(32'd28);
    chk("skip_err", {31'd0, error}, 32'd1);
    chk("skip_cause", {30'd0, err_cause}, 32'd1);
    chk("skip_busy", {31'd0, busy}, 32'd0);
    for (int i = 31; i >= 0; i--) begin put(32'(i)); put(32'd1); end
    idle(2);
    chk("skip_sticky", {30'd0, err_cause}, 32'd1);
    chk("skip_no_nd", 32'(nd_cnt - n0), 32'd0);
    chk("skip_keep_data", out_data, 32'hDEADBEEF);

    // bad value
    do_reset();
    put(32'd31); put(32'd2);
    chk("badval_err", {31'd0, error}, 32'd1);
    chk("badval_cause", {30'd0, err_cause}, 32'd2);
    put(32'd31); put(32'd0);
    idle(2);
    chk("badval_sticky", {30'd0, err_cause}, 32'd2);
    do_reset();
    n0 = nd_cnt;
    send_word(32'hFFFF0000, 1);
    idle(3);
    chk("after_rst_cnt", 32'(nd_cnt - n0), 32'd1);

    // upstream error code while a value is expected
    put(32'd31); put(32'd1); put(32'd30);
    put(32'hFFFFFFFF);
    chk("errcode_err", {31'd0, error}, 32'd1);
    chk("errcode_cause", {30'd0, err_cause}, 32'd3);

    // errcode in IDLE
    do_reset();
    put(32'hFFFFFFFF);
    chk("errcode_idle_cause", {30'd0, err_cause}, 32'd3);

    // reset mid-word
    do_reset();
    for (int i = 31; i > 11; i--) begin put(32'(i)); put(32'd1); end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    idle(2);
    reset = 1'b1;
    idle(1);
    n0 = nd_cnt;
    send_word(32'h12345678, 0);
    idle(3);
    chk("fresh_cnt", 32'(nd_cnt - n0), 32'd1);
    chk("fresh_pending", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
